// File: rtl/multiword_adder_ctrl_if.sv
// Handshake bundle between operand producer, word-serial adder and result consumer.
// The controller connects through the slave modport; a producer/consumer pair uses master.
interface multiword_adder_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
);
    localparam int TOTAL_W = WIDTH * WORDS;

    logic               i_valid;
    logic               o_ready;
    logic [TOTAL_W-1:0] i_A;
    logic [TOTAL_W-1:0] i_B;
    logic               i_carry;
    logic               o_valid;
    logic               i_ready;
    logic [TOTAL_W-1:0] o_S;
    logic               o_carry;
    logic               o_busy;

    modport slave (
        input  i_valid, i_A, i_B, i_carry, i_ready,
        output o_ready, o_valid, o_S, o_carry, o_busy
    );

    modport master (
        output i_valid, i_A, i_B, i_carry, i_ready,
        input  o_ready, o_valid, o_S, o_carry, o_busy
    );
endinterface

// File: rtl/multiword_adder_ctrl.sv
// Word-serial adder: one WIDTH-bit slice reused over WORDS cycles, LSW first,
// with a registered carry linking consecutive words.
module multiword_adder_ctrl #(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    multiword_adder_ctrl_if.slave bus
);
    localparam int TOTAL_W = WIDTH * WORDS;
    localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic               carry_q;
    logic [TOTAL_W-1:0] a_q;
    logic [TOTAL_W-1:0] b_q;
    logic [TOTAL_W-1:0] s_q;
    logic               cout_q;

    logic               accept;
    logic               last_word;
    logic [WIDTH-1:0]   word_a;
    logic [WIDTH-1:0]   word_b;
    logic [WIDTH:0]     slice_sum;

    // One word of the ripple-carry slice: {carry, sum} = a + b + cin.
    function automatic logic [WIDTH:0] add_word(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin
    );
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.i_valid) state_next = RUN;
            RUN:     if (last_word)   state_next = DONE;
            DONE:    if (bus.i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept    = (state == IDLE) && bus.i_valid;
    assign last_word = (idx == LAST_IDX);

    always_comb begin
        word_a    = a_q[int'(idx) * WIDTH +: WIDTH];
        word_b    = b_q[int'(idx) * WIDTH +: WIDTH];
        slice_sum = add_word(word_a, word_b, carry_q);
    end

    // Operands are captured once; later changes on the bus cannot disturb a running sum.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.i_A;
            b_q     <= bus.i_B;
            carry_q <= bus.i_carry;
            idx     <= '0;
        end else if (state == RUN) begin
            s_q[int'(idx) * WIDTH +: WIDTH] <= slice_sum[WIDTH-1:0];
            carry_q <= slice_sum[WIDTH];
            if (last_word) begin
                cout_q <= slice_sum[WIDTH];
                idx    <= '0;
            end else begin
                idx    <= idx + 1'b1;
            end
        end
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_busy  = (state == RUN);
    assign bus.o_valid = (state == DONE);
    assign bus.o_S     = s_q;
    assign bus.o_carry = cout_q;
endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Directed bench for the word-serial adder: WORDS=4 main instance plus a WORDS=1 instance.
module tb_multiword_adder_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   lat;

    multiword_adder_ctrl_if #(.WIDTH(4), .WORDS(4)) bus4 ();
    multiword_adder_ctrl_if #(.WIDTH(4), .WORDS(1)) bus1 ();

    multiword_adder_ctrl #(.WIDTH(4), .WORDS(4)) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus4)
    );

    multiword_adder_ctrl #(.WIDTH(4), .WORDS(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int guard;
        guard = 0;
        while (!bus4.o_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus4.o_ready) chk("ready_timeout", 32'(bus4.o_ready), 32'd1);
        bus4.i_valid = 1'b1;
        bus4.i_A     = a;
        bus4.i_B     = b;
        bus4.i_carry = cin;
        @(negedge clk);
        bus4.i_valid = 1'b0;
        bus4.i_A     = ~a;
        bus4.i_B     = ~b;
        bus4.i_carry = ~cin;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!bus4.o_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic collect(input int stall);
        for (int i = 0; i < stall; i++) @(negedge clk);
        bus4.i_ready = 1'b1;
        @(negedge clk);
        bus4.i_ready = 1'b0;
    endtask

    task automatic op_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input int stall);
        logic [16:0] model;
        model = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        issue(a, b, cin);
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd4);
        chk({tag, "_S"}, 32'(bus4.o_S), 32'(model[15:0]));
        chk({tag, "_carry"}, 32'(bus4.o_carry), 32'(model[16]));
        collect(stall);
    endtask

    initial begin
        logic [15:0] held_s;
        logic        held_c;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        int          results;

        checks  = 0;
        errors  = 0;
        results = 0;
        rst_n   = 1'b0;
        bus4.i_valid = 1'b0; bus4.i_A = '0; bus4.i_B = '0; bus4.i_carry = 1'b0; bus4.i_ready = 1'b0;
        bus1.i_valid = 1'b0; bus1.i_A = '0; bus1.i_B = '0; bus1.i_carry = 1'b0; bus1.i_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus4.o_ready), 32'd1);
        chk("rst_valid", 32'(bus4.o_valid), 32'd0);
        chk("rst_busy",  32'(bus4.o_busy),  32'd0);
        chk("rst_S",     32'(bus4.o_S),     32'd0);
        chk("rst_carry", 32'(bus4.o_carry), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Test 1: carry across a word boundary, latency exactly 4
        issue(16'h00FF, 16'h0001, 1'b0);
        chk("t1_busy", 32'(bus4.o_busy), 32'd1);
        chk("t1_ready_run", 32'(bus4.o_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_valid_early", 32'(bus4.o_valid), 32'd0);
        @(negedge clk);
        chk("t1_valid", 32'(bus4.o_valid), 32'd1);
        chk("t1_S", 32'(bus4.o_S), 32'h0100);
        chk("t1_carry", 32'(bus4.o_carry), 32'd0);
        collect(0);
        chk("t1_ready_after", 32'(bus4.o_ready), 32'd1);
        chk("t1_S_kept", 32'(bus4.o_S), 32'h0100);

        // Test 2: full ripple through all words
        op_check("t2a", 16'hFFFF, 16'h0001, 1'b0, 0);
        op_check("t2b", 16'hFFFF, 16'h0000, 1'b1, 0);

        // Test 3: backpressure in DONE with i_valid pulsing
        issue(16'h0F0F, 16'h0101, 1'b0);
        wait_valid(lat);
        chk("t3_lat", 32'(lat), 32'd4);
        held_s = bus4.o_S;
        held_c = bus4.o_carry;
        chk("t3_S", 32'(held_s), 32'h1010);
        for (int i = 0; i < 5; i++) begin
            bus4.i_valid = i[0];
            bus4.i_A     = 16'hAAAA;
            bus4.i_B     = 16'h5555;
            @(negedge clk);
            chk("t3_hold_valid", 32'(bus4.o_valid), 32'd1);
            chk("t3_hold_S", 32'(bus4.o_S), 32'h1010);
            chk("t3_hold_carry", 32'(bus4.o_carry), 32'(held_c));
            chk("t3_hold_ready", 32'(bus4.o_ready), 32'd0);
        end
        bus4.i_valid = 1'b0;
        collect(0);
        @(negedge clk);
        chk("t3_no_accept", 32'(bus4.o_busy), 32'd0);
        chk("t3_idle", 32'(bus4.o_ready), 32'd1);

        // Test 4: reset two RUN cycles into an operation
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4_valid", 32'(bus4.o_valid), 32'd0);
        chk("t4_S", 32'(bus4.o_S), 32'd0);
        chk("t4_ready", 32'(bus4.o_ready), 32'd1);
        chk("t4_busy", 32'(bus4.o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op_check("t4_next", 16'h1234, 16'h4321, 1'b0, 0);

        // Test 5: single-word instance
        bus1.i_valid = 1'b1;
        bus1.i_A     = 4'hF;
        bus1.i_B     = 4'h1;
        bus1.i_carry = 1'b0;
        @(negedge clk);
        bus1.i_valid = 1'b0;
        bus1.i_A     = 4'h0;
        chk("t5_busy", 32'(bus1.o_busy), 32'd1);
        @(negedge clk);
        chk("t5_valid", 32'(bus1.o_valid), 32'd1);
        chk("t5_S", 32'(bus1.o_S), 32'h0);
        chk("t5_carry", 32'(bus1.o_carry), 32'd1);
        bus1.i_ready = 1'b1;
        @(negedge clk);
        bus1.i_ready = 1'b0;
        chk("t5_ready", 32'(bus1.o_ready), 32'd1);

        // Test 6: random back-to-back operations with random consumer stalls
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            op_check("t6", ra, rb, rc, int'($urandom_range(0, 3)));
            results++;
        end
        chk("t6_count", 32'(results), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
